alu_ctr_encode: RTL and testbench

Instruction-side producer of the 4-bit ALU control code. It accepts RV32I instruction words over a valid/ready handshake and classifies each by opcode, funct3 and funct7. It emits the matching alu_ctr code plus an illegal flag through a registered, skid-buffered output stage. It sits between fetch/decode and the ALU-op one-hot decoder, so the two ends agree on a single encoding.

---
 rtl/alu_ctr_encode_pkg.sv | 35 +++
 rtl/alu_ctr_encode_classify.sv | 97 +++++++++
 rtl/alu_ctr_encode.sv | 138 +++++++++++++
 tb/tb_alu_ctr_encode.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_ctr_encode_pkg.sv
// Shared constants for the ALU control encoding: alu_ctr codes, RV32I opcodes
// and the output-stage occupancy states.
package alu_ctr_encode_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_ctr_encode_classify.sv
// Combinational classifier: maps an RV32I word to {illegal, alu_ctr}.
// An illegal word always reports ALU_ADD so the consumer sees a benign code.
module alu_ctr_encode_classify
    import alu_ctr_encode_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic        o_illegal,
    output logic [3:0]  o_alu_ctr
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_unused_bits;

    assign w_opc         = i_instr[6:0];
    assign w_f3          = i_instr[14:12];
    assign w_f7          = i_instr[31:25];
    assign w_unused_bits = ^{i_instr[24:15], i_instr[11:7]};

    // Opcode/funct decode into the shared alu_ctr encoding
    always_comb begin
        o_illegal = 1'b1;
        o_alu_ctr = ALU_ADD;
        case (w_opc)
            OPC_OP: begin
                if (w_f7 == F7_ZERO) begin
                    o_illegal = 1'b0;
                    o_alu_ctr = {1'b0, w_f3};
                end else if ((w_f7 == F7_ALT) && (w_f3 == 3'b000)) begin
                    o_illegal = 1'b0;
                    o_alu_ctr = ALU_SUB;
                end else if ((w_f7 == F7_ALT) && (w_f3 == 3'b101)) begin
                    o_illegal = 1'b0;
                    o_alu_ctr = ALU_SRA;
                end else begin
                    o_illegal = 1'b1;
                    o_alu_ctr = ALU_ADD;
                end
            end
            OPC_OP_IMM: begin
                // Only the shift immediates carry a funct7; elsewhere bit 30 is immediate data
                if (w_f3 == 3'b001) begin
                    o_illegal = (w_f7 != F7_ZERO);
                    o_alu_ctr = (w_f7 == F7_ZERO) ? ALU_SLL : ALU_ADD;
                end else if (w_f3 == 3'b101) begin
                    if (w_f7 == F7_ZERO) begin
                        o_illegal = 1'b0;
                        o_alu_ctr = ALU_SRL;
                    end else if (w_f7 == F7_ALT) begin
                        o_illegal = 1'b0;
                        o_alu_ctr = ALU_SRA;
                    end else begin
                        o_illegal = 1'b1;
                        o_alu_ctr = ALU_ADD;
                    end
                end else begin
                    o_illegal = 1'b0;
                    o_alu_ctr = {1'b0, w_f3};
                end
            end
            OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                o_illegal = 1'b0;
                o_alu_ctr = ALU_ADD;
            end
            OPC_JALR: begin
                o_illegal = (w_f3 != 3'b000);
                o_alu_ctr = ALU_ADD;
            end
            OPC_BRANCH: begin
                case (w_f3)
                    3'b000, 3'b001: begin
                        o_illegal = 1'b0;
                        o_alu_ctr = ALU_SUB;
                    end
                    3'b100, 3'b101: begin
                        o_illegal = 1'b0;
                        o_alu_ctr = ALU_SLT;
                    end
                    3'b110, 3'b111: begin
                        o_illegal = 1'b0;
                        o_alu_ctr = ALU_SLTU;
                    end
                    default: begin
                        o_illegal = 1'b1;
                        o_alu_ctr = ALU_ADD;
                    end
                endcase
            end
            default: begin
                o_illegal = 1'b1;
                o_alu_ctr = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctr_encode.sv
// ALU control encoder: classifies accepted instructions and presents the result
// through a registered output stage backed by one skid entry.
module alu_ctr_encode
    import alu_ctr_encode_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_ctr,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [3:0]       r_alu_ctr;
    logic             r_illegal;
    logic [3:0]       r_skid_ctr;
    logic             r_skid_illegal;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_cls_illegal;
    logic [3:0]       w_cls_ctr;
    logic             w_load_out;
    logic             w_load_skid;
    logic             w_from_skid;

    alu_ctr_encode_classify u_classify (
        .i_instr   (in_instr),
        .o_illegal (w_cls_illegal),
        .o_alu_ctr (w_cls_ctr)
    );

    assign w_accept = in_valid && r_in_ready;

    // Occupancy next-state and register load selects
    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_load_out  = 1'b1;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_accept && out_ready) begin
                    w_state_nxt = ST_ONE;
                    w_load_out  = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    w_state_nxt = ST_ONE;
                    w_from_skid = 1'b1;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State, handshake flags and output/skid payload registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_EMPTY;
            r_out_valid    <= 1'b0;
            r_in_ready     <= 1'b1;
            r_alu_ctr      <= ALU_ADD;
            r_illegal      <= 1'b0;
            r_skid_ctr     <= ALU_ADD;
            r_skid_illegal <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
            if (w_load_out) begin
                r_alu_ctr <= w_cls_ctr;
                r_illegal <= w_cls_illegal;
            end else if (w_from_skid) begin
                r_alu_ctr <= r_skid_ctr;
                r_illegal <= r_skid_illegal;
            end else begin
                r_alu_ctr <= r_alu_ctr;
                r_illegal <= r_illegal;
            end
            if (w_load_skid) begin
                r_skid_ctr     <= w_cls_ctr;
                r_skid_illegal <= w_cls_illegal;
            end else begin
                r_skid_ctr     <= r_skid_ctr;
                r_skid_illegal <= r_skid_illegal;
            end
        end
    end

    // Saturating count of accepted illegal words
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept && w_cls_illegal && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign alu_ctr     = r_alu_ctr;
    assign illegal     = r_illegal;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_alu_ctr_encode.sv
// Scoreboard bench for alu_ctr_encode: directed instruction words with
// hand-computed {illegal, alu_ctr}, plus backpressure, reset and saturation cases.
module tb_alu_ctr_encode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctr;
    logic        illegal;
    logic [15:0] illegal_cnt;

    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_instr;
    logic        s_out_valid;
    logic [3:0]  s_alu_ctr;
    logic        s_illegal;
    logic [1:0]  s_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [4:0]  sb[$];
    logic [4:0]  mon_exp;
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    alu_ctr_encode #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctr(alu_ctr), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    alu_ctr_encode #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready),
        .in_instr(s_instr), .out_valid(s_out_valid), .out_ready(1'b1),
        .alu_ctr(s_alu_ctr), .illegal(s_illegal), .illegal_cnt(s_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Offers one word; expectation is queued only for results that must appear.
    task automatic send(input logic [31:0] ins, input logic [4:0] exp, input bit push);
        int t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0 for %0d cycles, instr=%h", t, ins);
        end else begin
            in_valid = 1'b1;
            in_instr = ins;
            if (push) sb.push_back(exp);
            if (exp[4]) exp_cnt++;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    // Monitor: pops an expectation for every output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got illegal=%0b alu_ctr=%b, nothing expected",
                         illegal, alu_ctr);
            end else begin
                mon_exp = sb.pop_front();
                if ({illegal, alu_ctr} !== mon_exp) begin
                    errors++;
                    $display("FAIL out_data: got illegal=%0b alu_ctr=%b, expected illegal=%0b alu_ctr=%b",
                             illegal, alu_ctr, mon_exp[4], mon_exp[3:0]);
                end
            end
        end
    end

    logic [31:0] vec_i[17] = '{
        32'h003100B3, 32'h403100B3, 32'h40315093, 32'h40010093,
        32'h0020E463, 32'h0020C463, 32'h00208463, 32'h023100B3,
        32'h4020D0B3, 32'h0020F0B3, 32'h0050D093, 32'h40011093,
        32'h000010B7, 32'h00001067, 32'h00002063, 32'h0000007F,
        32'h0000B013
    };
    logic [4:0] vec_e[17] = '{
        5'b0_0000, 5'b0_1000, 5'b0_1101, 5'b0_0000,
        5'b0_0011, 5'b0_0010, 5'b0_1000, 5'b1_0000,
        5'b0_1101, 5'b0_0111, 5'b0_0101, 5'b1_0000,
        5'b0_0000, 5'b1_0000, 5'b1_0000, 5'b1_0000,
        5'b0_0011
    };

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b1;
        s_valid = 1'b0; s_instr = 32'h0000007F;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_alu_ctr", {28'h0, alu_ctr}, 32'h0);
        chk("rst_illegal", {31'h0, illegal}, 32'h0);
        chk("rst_cnt", {16'h0, illegal_cnt}, 32'h0);

        // Streaming with out_ready=1: one word per cycle
        for (int i = 0; i < 17; i++) begin
            send(vec_i[i], vec_e[i], 1'b1);
            chk("illegal_cnt", {16'h0, illegal_cnt}, exp_cnt);
        end
        repeat (3) @(posedge clk); #1;
        chk("stream_drained", sb.size(), 32'h0);
        chk("stream_idle", {31'h0, out_valid}, 32'h0);

        // Backpressure: two accepts fill output + skid, third word held off
        out_ready = 1'b0;
        send(32'h003100B3, 5'b0_0000, 1'b1);
        chk("bp_ready_after1", {31'h0, in_ready}, 32'h1);
        send(32'h403100B3, 5'b0_1000, 1'b1);
        chk("bp_ready_after2", {31'h0, in_ready}, 32'h0);
        in_valid = 1'b1;
        in_instr = 32'h40315093;
        repeat (2) @(posedge clk); #1;
        chk("bp_held_ready", {31'h0, in_ready}, 32'h0);
        chk("bp_held_valid", {31'h0, out_valid}, 32'h1);
        chk("bp_stable_ctr", {28'h0, alu_ctr}, 32'h0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_release", {31'h0, in_ready}, 32'h1);
        chk("bp_skid_moved", {28'h0, alu_ctr}, 32'h8);
        sb.push_back(5'b0_1101);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_third_loaded", {28'h0, alu_ctr}, 32'hD);
        repeat (3) @(posedge clk); #1;
        chk("bp_drained", sb.size(), 32'h0);

        // Reset while FULL discards both held results
        out_ready = 1'b0;
        send(32'h0020F0B3, 5'b0_0111, 1'b0);
        send(32'h023100B3, 5'b1_0000, 1'b0);
        chk("full_ready", {31'h0, in_ready}, 32'h0);
        chk("full_cnt", {16'h0, illegal_cnt}, exp_cnt);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstfull_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rstfull_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rstfull_cnt", {16'h0, illegal_cnt}, 32'h0);
        rst = 1'b0;
        exp_cnt = 0;
        out_ready = 1'b1;
        send(32'h0050D093, 5'b0_0101, 1'b1);
        repeat (4) @(posedge clk); #1;
        chk("post_rst_drained", sb.size(), 32'h0);
        chk("post_rst_idle", {31'h0, out_valid}, 32'h0);

        // Saturation on a 2-bit counter instance
        s_valid = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("sat_two", {30'h0, s_cnt}, 32'h2);
        repeat (4) @(posedge clk); #1;
        chk("sat_hold", {30'h0, s_cnt}, 32'h3);
        s_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
